// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a byte FIFO, sticky error flags and a byte counter.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_monitor #(
   parameter int CLK_DIV    = 217,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic        uart_rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic        err_clr,
   output logic        frame_err,
   output logic        overrun,
   output logic        parity_err,
   output logic [15:0] byte_cnt
);

   // state     | meaning
   // S_IDLE    | line idle, waiting for a falling edge
   // S_START   | half a bit into the start bit, confirm it is still low
   // S_DATA    | sampling 8 data bits, LSB first
   // S_PARITY  | sampling the even-parity bit (parity build only)
   // S_STOP    | sampling the stop bit
   // S_WAIT_HI | bad stop bit, wait for the line to return high
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   localparam int          AW          = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
   localparam logic [AW:0] PTR_ONE     = (AW + 1)'(1);

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        push_q, push_d;
   logic        rx_meta_q, rx_meta_d;
   logic        rx_s_q, rx_s_d;
   logic        rx_d_q, rx_d_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
`ifdef UART_RX_PARITY_EN
   logic        parity_err_q, parity_err_d;
   logic        parity_set;
`endif

   logic tick;
   logic frame_set;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push_ok;

   always_comb begin
      rx_meta_d = uart_rx;
      rx_s_d    = rx_meta_q;
      rx_d_d    = rx_s_q;

      tick      = (timer_q == 16'd0);
      state_d   = state_q;
      timer_d   = tick ? timer_q : timer_q - 16'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (rx_d_q && !rx_s_q) begin
               state_d = S_START;
               timer_d = HALF_RELOAD;
            end
         end
         S_START: begin
            if (tick) begin
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
                  timer_d   = BIT_RELOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               timer_d   = BIT_RELOAD;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               parity_set = (rx_s_q != ^shift_q);
               state_d    = S_STOP;
               timer_d    = BIT_RELOAD;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rx_s_q) begin
                  push_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_d   = S_WAIT_HI;
               end
            end
         end
         S_WAIT_HI: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !fifo_empty && rx_ready;
      push_ok    = push_q && (!fifo_full || pop);

      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = shift_q;
      wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      byte_cnt_d = push_ok ? byte_cnt_q + 16'd1 : byte_cnt_q;

      frame_err_d = (frame_err_q && !err_clr) || frame_set;
      overrun_d   = (overrun_q && !err_clr) || (push_q && fifo_full && !pop);
`ifdef UART_RX_PARITY_EN
      parity_err_d = (parity_err_q && !err_clr) || parity_set;
`endif
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q     <= S_IDLE;
         timer_q     <= 16'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         push_q      <= 1'b0;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         byte_cnt_q  <= 16'd0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         push_q      <= push_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_d_q      <= rx_d_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         byte_cnt_q  <= byte_cnt_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_valid  = !fifo_empty;
   assign rx_data   = mem_q[rd_ptr_q[AW-1:0]];
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign byte_cnt  = byte_cnt_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor at CLK_DIV=8, FIFO_DEPTH=8.
// Parity scenario is compiled in only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_monitor;

   localparam int CLK_DIV    = 8;
   localparam int FIFO_DEPTH = 8;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn;
   logic        uart_rx;
   logic        rx_ready;
   logic        err_clr;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        overrun;
   logic        parity_err;
   logic [15:0] byte_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  mon_exp;
   int          pop_cnt   = 0;
   int          valid_run = 0;
   int          max_run   = 0;
   logic [15:0] exp_cnt   = 16'd0;

   uart_rx_monitor #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rstn   (cpu_rstn),
      .uart_rx    (uart_rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .err_clr    (err_clr),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .byte_cnt   (byte_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Inputs only change on negedges, so values seen 1ns later hold through the next posedge.
   always @(negedge cpu_clk) begin
      #1;
      if (cpu_rstn) begin
         if (rx_valid) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
         end else begin
            valid_run = 0;
         end
         if (rx_valid && rx_ready) begin
            pop_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_byte: got %02h, none expected", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rx_data !== mon_exp) begin
                  n_bad++;
                  $display("FAIL rx_data: got %02h want %02h", rx_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                             input bit rdy_pulse);
      @(negedge cpu_clk);
      uart_rx = 1'b0;
      repeat (CLK_DIV) @(negedge cpu_clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (CLK_DIV) @(negedge cpu_clk);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = par_b;
      repeat (CLK_DIV) @(negedge cpu_clk);
`else
      if (par_b === 1'bz) uart_rx = 1'b1;
`endif
      uart_rx = stop_b;
      if (rdy_pulse) begin
         // rx_ready high only across the edge that writes the byte
         repeat (CLK_DIV - 1) @(negedge cpu_clk);
         rx_ready = 1'b1;
         @(negedge cpu_clk);
         rx_ready = 1'b0;
      end else begin
         repeat (CLK_DIV) @(negedge cpu_clk);
      end
      if (stop_b) repeat (2) @(negedge cpu_clk);
   endtask

   task automatic test_reset();
      cpu_rstn = 1'b0;
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      repeat (3) @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      @(negedge cpu_clk);
      n_cmp++; if (rx_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_data !== 8'h00)    begin n_bad++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
      n_cmp++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (overrun !== 1'b0)     begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      n_cmp++; if (parity_err !== 1'b0)  begin n_bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
      n_cmp++; if (byte_cnt !== 16'd0)   begin n_bad++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end

      // reset in the middle of a frame must drop the partial byte
      uart_rx = 1'b0;
      repeat (30) @(negedge cpu_clk);
      cpu_rstn = 1'b0;
      #1;
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_rx_valid: got %b want 0", rx_valid); end
      uart_rx = 1'b1;
      repeat (3) @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      repeat (100) @(negedge cpu_clk);
      n_cmp++; if (rx_valid !== 1'b0)   begin n_bad++; $display("FAIL midreset_no_push: got %b want 0", rx_valid); end
      n_cmp++; if (byte_cnt !== 16'd0)  begin n_bad++; $display("FAIL midreset_byte_cnt: got %0d want 0", byte_cnt); end
      n_cmp++; if (frame_err !== 1'b0)  begin n_bad++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
   endtask

   task automatic test_single_byte();
      rx_ready = 1'b1;
      max_run  = 0;
      exp_q.push_back(8'hA5);
      exp_cnt++;
      send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      repeat (4) @(negedge cpu_clk);
      n_cmp++; if (exp_q.size() != 0)   begin n_bad++; $display("FAIL single_drain: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (max_run != 1)        begin n_bad++; $display("FAIL single_valid_width: got %0d want 1", max_run); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL single_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000)
         begin n_bad++; $display("FAIL single_flags: got %b want 000", {frame_err, overrun, parity_err}); end
   endtask

   task automatic test_glitch();
      rx_ready = 1'b1;
      @(negedge cpu_clk);
      uart_rx = 1'b0;
      repeat (3) @(negedge cpu_clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge cpu_clk);
      n_cmp++; if (rx_valid !== 1'b0)    begin n_bad++; $display("FAIL glitch_no_push: got %b want 0", rx_valid); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL glitch_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      n_cmp++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
      exp_q.push_back(8'h3C);
      exp_cnt++;
      send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      n_cmp++; if (exp_q.size() != 0)    begin n_bad++; $display("FAIL glitch_follow_drain: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL glitch_follow_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
   endtask

   task automatic test_frame_err();
      rx_ready = 1'b1;
      send_frame(8'h55, 1'b0, ^8'h55, 1'b0);
      repeat (40) @(negedge cpu_clk);
      uart_rx = 1'b1;
      repeat (10) @(negedge cpu_clk);
      n_cmp++; if (frame_err !== 1'b1)   begin n_bad++; $display("FAIL frame_err_set: got %b want 1", frame_err); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL frame_err_no_push: got %0d want %0d", byte_cnt, exp_cnt); end
      exp_q.push_back(8'h0F);
      exp_cnt++;
      send_frame(8'h0F, 1'b1, ^8'h0F, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      n_cmp++; if (exp_q.size() != 0)    begin n_bad++; $display("FAIL frame_follow_drain: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (frame_err !== 1'b1)   begin n_bad++; $display("FAIL frame_err_sticky: got %b want 1", frame_err); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL frame_follow_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      err_clr = 1'b1;
      @(negedge cpu_clk);
      err_clr = 1'b0;
      @(negedge cpu_clk);
      n_cmp++; if (frame_err !== 1'b0)   begin n_bad++; $display("FAIL frame_err_clr: got %b want 0", frame_err); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL clr_keeps_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
   endtask

   task automatic test_overrun();
      logic [7:0] b;
      rx_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         b = 8'(k);
         if (k < FIFO_DEPTH) begin
            exp_q.push_back(b);
            exp_cnt++;
         end
         send_frame(b, 1'b1, ^b, 1'b0);
      end
      repeat (4) @(negedge cpu_clk);
      n_cmp++; if (overrun !== 1'b1)     begin n_bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL overrun_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      rx_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      repeat (2) @(negedge cpu_clk);
      n_cmp++; if (exp_q.size() != 0)    begin n_bad++; $display("FAIL overrun_drain: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (rx_valid !== 1'b0)    begin n_bad++; $display("FAIL overrun_empty: got %b want 0", rx_valid); end
      err_clr = 1'b1;
      @(negedge cpu_clk);
      err_clr = 1'b0;
      @(negedge cpu_clk);
      n_cmp++; if (overrun !== 1'b0)     begin n_bad++; $display("FAIL overrun_clr: got %b want 0", overrun); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] b;
      int         base;
      rx_ready = 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         b = 8'h10 + 8'(k);
         exp_q.push_back(b);
         exp_cnt++;
         send_frame(b, 1'b1, ^b, 1'b0);
      end
      exp_q.push_back(8'h99);
      exp_cnt++;
      send_frame(8'h99, 1'b1, ^8'h99, 1'b1);
      repeat (4) @(negedge cpu_clk);
      n_cmp++; if (overrun !== 1'b0)     begin n_bad++; $display("FAIL full_pp_overrun: got %b want 0", overrun); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL full_pp_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      base     = pop_cnt;
      rx_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      repeat (4) @(negedge cpu_clk);
      n_cmp++; if (pop_cnt - base != FIFO_DEPTH)
         begin n_bad++; $display("FAIL full_pp_occupancy: got %0d want %0d", pop_cnt - base, FIFO_DEPTH); end
      n_cmp++; if (exp_q.size() != 0)    begin n_bad++; $display("FAIL full_pp_drain: got %0d left want 0", exp_q.size()); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      rx_ready = 1'b1;
      exp_q.push_back(8'h07);
      exp_cnt++;
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      n_cmp++; if (exp_q.size() != 0)    begin n_bad++; $display("FAIL parity_drain: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (parity_err !== 1'b1)  begin n_bad++; $display("FAIL parity_err_set: got %b want 1", parity_err); end
      err_clr = 1'b1;
      @(negedge cpu_clk);
      err_clr = 1'b0;
      @(negedge cpu_clk);
      n_cmp++; if (parity_err !== 1'b0)  begin n_bad++; $display("FAIL parity_err_clr: got %b want 0", parity_err); end
      exp_q.push_back(8'h03);
      exp_cnt++;
      send_frame(8'h03, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge cpu_clk);
      n_cmp++; if (parity_err !== 1'b0)  begin n_bad++; $display("FAIL parity_good: got %b want 0", parity_err); end
      n_cmp++; if (byte_cnt !== exp_cnt) begin n_bad++; $display("FAIL parity_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_full_push_pop();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      repeat (4) @(negedge cpu_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
